// File: rtl/alu_logic_unit.sv
// Pipelined bitwise logic unit with accumulator feedback, result flags and a
// 2-entry output buffer; drives the logic input of the ALU result mux.
module alu_logic_unit #(
    parameter int WIDTH = 8
) (
    input  logic             clk,
    input  logic             rst_n,
    input  logic             in_valid,
    output logic             in_ready,
    input  logic [2:0]       in_op,
    input  logic [WIDTH-1:0] in_a,
    input  logic [WIDTH-1:0] in_b,
    input  logic             in_acc,
    input  logic             acc_clr,
    output logic             out_valid,
    input  logic             out_ready,
    output logic [WIDTH-1:0] out_result,
    output logic             out_zero,
    output logic             out_ones,
    output logic             out_parity
);

    typedef struct packed {
        logic [WIDTH-1:0] result;
        logic             zero;
        logic             ones;
        logic             parity;
    } entry_t;

    function automatic logic calc_parity(input logic [WIDTH-1:0] v);
        return ^v;
    endfunction

    function automatic logic calc_zero(input logic [WIDTH-1:0] v);
        return ~|v;
    endfunction

    function automatic logic calc_ones(input logic [WIDTH-1:0] v);
        return &v;
    endfunction

    logic [WIDTH-1:0] w_acc_eff;
    logic [WIDTH-1:0] w_b;
    logic [WIDTH-1:0] w_result;
    entry_t           w_entry;
    logic             w_accept;
    logic             w_pop;
    logic [1:0]       w_count_nxt;

    logic [WIDTH-1:0] r_acc;
    logic [1:0]       r_count;
    entry_t           r_head;
    entry_t           r_tail;
    logic             r_in_ready;
    logic             r_out_valid;

    assign w_accept = in_valid & r_in_ready;
    assign w_pop    = r_out_valid & out_ready;

    // Operand B selection and the bitwise operation itself.
    always_comb begin
        w_acc_eff = acc_clr ? {WIDTH{1'b0}} : r_acc;
        w_b       = in_acc ? w_acc_eff : in_b;
        case (in_op)
            3'd0:    w_result = in_a & w_b;
            3'd1:    w_result = in_a | w_b;
            3'd2:    w_result = in_a ^ w_b;
            3'd3:    w_result = ~(in_a & w_b);
            3'd4:    w_result = ~(in_a | w_b);
            3'd5:    w_result = ~(in_a ^ w_b);
            3'd6:    w_result = ~in_a;
            3'd7:    w_result = in_a;
            default: w_result = {WIDTH{1'b0}};
        endcase
        w_entry.result = w_result;
        w_entry.zero   = calc_zero(w_result);
        w_entry.ones   = calc_ones(w_result);
        w_entry.parity = calc_parity(w_result);
    end

    // Next buffer occupancy; accept+pop together leaves it unchanged.
    always_comb begin
        case ({w_accept, w_pop})
            2'b10:   w_count_nxt = r_count + 2'd1;
            2'b01:   w_count_nxt = r_count - 2'd1;
            default: w_count_nxt = r_count;
        endcase
    end

    // Accumulator: loads every accepted result, otherwise honours a clear.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            r_acc <= {WIDTH{1'b0}};
        end else if (w_accept) begin
            r_acc <= w_result;
        end else if (acc_clr) begin
            r_acc <= {WIDTH{1'b0}};
        end else begin
            r_acc <= r_acc;
        end
    end

    // Two-entry buffer; the head register doubles as the output register and
    // keeps the last popped value when the buffer drains.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            r_count       <= 2'd0;
            r_head.result <= {WIDTH{1'b0}};
            r_head.zero   <= 1'b1;
            r_head.ones   <= 1'b0;
            r_head.parity <= 1'b0;
            r_tail        <= '0;
            r_in_ready    <= 1'b1;
            r_out_valid   <= 1'b0;
        end else begin
            case ({w_accept, w_pop})
                2'b10: begin
                    if (r_count == 2'd0) begin
                        r_head <= w_entry;
                    end else begin
                        r_tail <= w_entry;
                    end
                end
                2'b01: begin
                    if (r_count == 2'd2) begin
                        r_head <= r_tail;
                    end else begin
                        r_head <= r_head;
                    end
                end
                // Only reachable with one entry held: the new result becomes head.
                2'b11: begin
                    r_head <= w_entry;
                end
                default: begin
                    r_head <= r_head;
                end
            endcase
            r_count     <= w_count_nxt;
            r_in_ready  <= (w_count_nxt < 2'd2);
            r_out_valid <= (w_count_nxt != 2'd0);
        end
    end

    assign in_ready   = r_in_ready;
    assign out_valid  = r_out_valid;
    assign out_result = r_head.result;
    assign out_zero   = r_head.zero;
    assign out_ones   = r_head.ones;
    assign out_parity = r_head.parity;

endmodule

// File: tb/tb_alu_logic_unit.sv
// Self-checking bench for alu_logic_unit: directed scenarios plus a randomized
// run scored against a queue-based reference model.
module tb_alu_logic_unit;

    logic       clk = 1'b0;
    logic       rst_n;
    logic       in_valid;
    logic       in_ready;
    logic [2:0] in_op;
    logic [7:0] in_a;
    logic [7:0] in_b;
    logic       in_acc;
    logic       acc_clr;
    logic       out_valid;
    logic       out_ready;
    logic [7:0] out_result;
    logic       out_zero;
    logic       out_ones;
    logic       out_parity;

    int checks   = 0;
    int failures = 0;

    logic [7:0] mq[$];
    logic [7:0] m_acc;
    logic [7:0] m_last;

    always #5 clk = ~clk;

    alu_logic_unit #(.WIDTH(8)) dut (
        .clk        (clk),
        .rst_n      (rst_n),
        .in_valid   (in_valid),
        .in_ready   (in_ready),
        .in_op      (in_op),
        .in_a       (in_a),
        .in_b       (in_b),
        .in_acc     (in_acc),
        .acc_clr    (acc_clr),
        .out_valid  (out_valid),
        .out_ready  (out_ready),
        .out_result (out_result),
        .out_zero   (out_zero),
        .out_ones   (out_ones),
        .out_parity (out_parity)
    );

    function automatic logic [7:0] ref_op(input logic [2:0] op, input logic [7:0] a, input logic [7:0] b);
        case (op)
            3'd0:    return a & b;
            3'd1:    return a | b;
            3'd2:    return a ^ b;
            3'd3:    return 8'hFF ^ (a & b);
            3'd4:    return 8'hFF ^ (a | b);
            3'd5:    return 8'hFF ^ (a ^ b);
            3'd6:    return 8'hFF - a;
            default: return a;
        endcase
    endfunction

    function automatic logic [7:0] exp_head();
        return (mq.size() > 0) ? mq[0] : m_last;
    endfunction

    // One clock of stimulus; the model advances at the same edge.
    task automatic cyc(input logic v, input logic [2:0] op, input logic [7:0] a, input logic [7:0] b,
                       input logic acc, input logic clr, input logic rdy);
        logic       acc_ok;
        logic       pop;
        logic [7:0] bval;
        logic [7:0] res;
        in_valid  = v;
        in_op     = op;
        in_a      = a;
        in_b      = b;
        in_acc    = acc;
        acc_clr   = clr;
        out_ready = rdy;
        acc_ok = v && (mq.size() < 2);
        pop    = (mq.size() > 0) && rdy;
        bval   = acc ? (clr ? 8'h00 : m_acc) : b;
        res    = ref_op(op, a, bval);
        @(posedge clk);
        #1;
        if (pop) m_last = mq.pop_front();
        if (acc_ok) begin
            mq.push_back(res);
            m_acc = res;
        end else if (clr) begin
            m_acc = 8'h00;
        end
    endtask

    task automatic do_reset();
        in_valid  = 1'b0;
        in_op     = 3'd0;
        in_a      = 8'h00;
        in_b      = 8'h00;
        in_acc    = 1'b0;
        acc_clr   = 1'b0;
        out_ready = 1'b0;
        rst_n     = 1'b0;
        mq.delete();
        m_acc  = 8'h00;
        m_last = 8'h00;
        repeat (2) @(posedge clk);
        @(negedge clk);
        rst_n = 1'b1;
        @(posedge clk);
        #1;
    endtask

    task automatic test_reset();
        do_reset();
        checks++; if (out_valid !== 1'b0)    begin failures++; $display("FAIL reset_valid got=%b exp=0", out_valid); end
        checks++; if (in_ready !== 1'b1)     begin failures++; $display("FAIL reset_in_ready got=%b exp=1", in_ready); end
        checks++; if (out_result !== 8'h00)  begin failures++; $display("FAIL reset_result got=%h exp=00", out_result); end
        checks++; if ({out_zero, out_ones, out_parity} !== 3'b100)
            begin failures++; $display("FAIL reset_flags got=%b exp=100", {out_zero, out_ones, out_parity}); end
    endtask

    task automatic test_basic();
        cyc(1'b1, 3'd0, 8'hF0, 8'h3C, 1'b0, 1'b0, 1'b1);
        checks++; if (out_valid !== 1'b1)   begin failures++; $display("FAIL basic_valid got=%b exp=1", out_valid); end
        checks++; if (out_result !== 8'h30) begin failures++; $display("FAIL basic_result got=%h exp=30", out_result); end
        checks++; if ({out_zero, out_ones, out_parity} !== 3'b000)
            begin failures++; $display("FAIL basic_flags got=%b exp=000", {out_zero, out_ones, out_parity}); end
        cyc(1'b0, 3'd0, 8'h00, 8'h00, 1'b0, 1'b0, 1'b1);
        checks++; if (out_valid !== 1'b0)   begin failures++; $display("FAIL basic_drain got=%b exp=0", out_valid); end
        checks++; if (out_result !== 8'h30) begin failures++; $display("FAIL basic_hold got=%h exp=30", out_result); end
    endtask

    task automatic test_all_ops();
        logic [7:0] exp_tab [8] = '{8'h05, 8'hAF, 8'hAA, 8'hFA, 8'h50, 8'h55, 8'h5A, 8'hA5};
        for (int i = 0; i < 8; i++) begin
            cyc(1'b1, 3'(i), 8'hA5, 8'h0F, 1'b0, 1'b0, 1'b1);
            checks++;
            if (out_valid !== 1'b1 || out_result !== exp_tab[i]) begin
                failures++;
                $display("FAIL all_ops op=%0d got=%b/%h exp=1/%h", i, out_valid, out_result, exp_tab[i]);
            end
        end
        cyc(1'b0, 3'd0, 8'h00, 8'h00, 1'b0, 1'b0, 1'b1);
    endtask

    task automatic test_acc_chain();
        logic [2:0] ops  [4] = '{3'd1, 3'd1, 3'd2, 3'd2};
        logic [7:0] as   [4] = '{8'h01, 8'h80, 8'hFF, 8'h0F};
        logic       clrs [4] = '{1'b0, 1'b0, 1'b1, 1'b0};
        logic [7:0] exps [4] = '{8'h01, 8'h81, 8'hFF, 8'hF0};
        do_reset();
        for (int i = 0; i < 4; i++) begin
            cyc(1'b1, ops[i], as[i], 8'h55, 1'b1, clrs[i], 1'b1);
            checks++;
            if (out_result !== exps[i]) begin
                failures++;
                $display("FAIL acc_chain step=%0d got=%h exp=%h", i, out_result, exps[i]);
            end
        end
        cyc(1'b0, 3'd0, 8'h00, 8'h00, 1'b0, 1'b0, 1'b1);
    endtask

    task automatic test_backpressure();
        cyc(1'b1, 3'd7, 8'h11, 8'h00, 1'b0, 1'b0, 1'b0);
        checks++; if (in_ready !== 1'b1) begin failures++; $display("FAIL bp_ready1 got=%b exp=1", in_ready); end
        cyc(1'b1, 3'd7, 8'h22, 8'h00, 1'b0, 1'b0, 1'b0);
        checks++; if (in_ready !== 1'b0) begin failures++; $display("FAIL bp_ready2 got=%b exp=0", in_ready); end
        cyc(1'b1, 3'd7, 8'h33, 8'h00, 1'b0, 1'b0, 1'b0);
        checks++; if (in_ready !== 1'b0 || out_result !== 8'h11)
            begin failures++; $display("FAIL bp_held got=%b/%h exp=0/11", in_ready, out_result); end
        cyc(1'b1, 3'd7, 8'h33, 8'h00, 1'b0, 1'b0, 1'b1);
        checks++; if (in_ready !== 1'b1 || out_result !== 8'h22)
            begin failures++; $display("FAIL bp_pop1 got=%b/%h exp=1/22", in_ready, out_result); end
        cyc(1'b1, 3'd7, 8'h33, 8'h00, 1'b0, 1'b0, 1'b1);
        checks++; if (out_valid !== 1'b1 || out_result !== 8'h33)
            begin failures++; $display("FAIL bp_pop2 got=%b/%h exp=1/33", out_valid, out_result); end
        cyc(1'b0, 3'd0, 8'h00, 8'h00, 1'b0, 1'b0, 1'b1);
        checks++; if (out_valid !== 1'b0 || out_result !== 8'h33)
            begin failures++; $display("FAIL bp_drain got=%b/%h exp=0/33", out_valid, out_result); end
    endtask

    task automatic test_flags();
        cyc(1'b1, 3'd3, 8'h00, 8'h00, 1'b0, 1'b0, 1'b1);
        checks++; if (out_result !== 8'hFF || {out_zero, out_ones, out_parity} !== 3'b010)
            begin failures++; $display("FAIL flags_ones got=%h/%b exp=ff/010", out_result, {out_zero, out_ones, out_parity}); end
        cyc(1'b1, 3'd0, 8'h00, 8'h00, 1'b0, 1'b0, 1'b1);
        checks++; if (out_result !== 8'h00 || {out_zero, out_ones, out_parity} !== 3'b100)
            begin failures++; $display("FAIL flags_zero got=%h/%b exp=00/100", out_result, {out_zero, out_ones, out_parity}); end
        cyc(1'b1, 3'd7, 8'h07, 8'h00, 1'b0, 1'b0, 1'b1);
        checks++; if ({out_zero, out_ones, out_parity} !== 3'b001)
            begin failures++; $display("FAIL flags_parity got=%b exp=001", {out_zero, out_ones, out_parity}); end
        cyc(1'b0, 3'd0, 8'h00, 8'h00, 1'b0, 1'b0, 1'b1);
    endtask

    task automatic test_reset_midstream();
        cyc(1'b1, 3'd7, 8'h3C, 8'h00, 1'b0, 1'b0, 1'b0);
        cyc(1'b1, 3'd7, 8'h5A, 8'h00, 1'b0, 1'b0, 1'b0);
        checks++; if (out_valid !== 1'b1 || in_ready !== 1'b0)
            begin failures++; $display("FAIL mid_full got=%b/%b exp=1/0", out_valid, in_ready); end
        in_valid = 1'b0;
        rst_n    = 1'b0;
        #1;
        checks++; if (out_valid !== 1'b0 || in_ready !== 1'b1)
            begin failures++; $display("FAIL mid_async got=%b/%b exp=0/1", out_valid, in_ready); end
        mq.delete();
        m_acc  = 8'h00;
        m_last = 8'h00;
        @(negedge clk);
        rst_n = 1'b1;
        @(posedge clk);
        #1;
        cyc(1'b1, 3'd1, 8'h00, 8'hAA, 1'b1, 1'b0, 1'b1);
        checks++; if (out_valid !== 1'b1 || out_result !== 8'h00)
            begin failures++; $display("FAIL mid_acc got=%b/%h exp=1/00", out_valid, out_result); end
        cyc(1'b0, 3'd0, 8'h00, 8'h00, 1'b0, 1'b0, 1'b1);
    endtask

    task automatic test_random();
        logic [7:0] e;
        for (int i = 0; i < 400; i++) begin
            cyc(1'($urandom_range(0, 3) != 0), 3'($urandom_range(0, 7)), 8'($urandom), 8'($urandom),
                1'($urandom_range(0, 1)), 1'($urandom_range(0, 7) == 0), 1'($urandom_range(0, 2) != 0));
            e = exp_head();
            checks++;
            if (in_ready !== (mq.size() < 2) || out_valid !== (mq.size() > 0) || out_result !== e ||
                out_zero !== (e == 8'h00) || out_ones !== (e == 8'hFF) || out_parity !== ^e) begin
                failures++;
                $display("FAIL random cyc=%0d got rdy=%b v=%b r=%h f=%b exp rdy=%b v=%b r=%h",
                         i, in_ready, out_valid, out_result, {out_zero, out_ones, out_parity},
                         (mq.size() < 2), (mq.size() > 0), e);
            end
        end
    endtask

    initial begin
        test_reset();
        test_basic();
        test_all_ops();
        test_acc_chain();
        test_backpressure();
        test_flags();
        test_reset_midstream();
        test_random();
        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

endmodule
